// File: rtl/xrv_dmem_if.sv
// Data-bus bundle between the execute stage (master) and the data memory (slave).
interface xrv_dmem_if;
    logic [31:0] d_addr;
    logic        d_wr_req;
    logic [3:0]  d_be;
    logic [31:0] d_wr_data;
    logic        d_wr_ready;
    logic        d_rd_req;
    logic        d_rd_ready;
    logic [31:0] d_rd_data;
    logic        bus_err;

    modport master (
        output d_addr, d_wr_req, d_be, d_wr_data, d_rd_req,
        input  d_wr_ready, d_rd_ready, d_rd_data, bus_err
    );

    modport slave (
        input  d_addr, d_wr_req, d_be, d_wr_data, d_rd_req,
        output d_wr_ready, d_rd_ready, d_rd_data, bus_err
    );
endinterface

// File: rtl/xrv_dmem.sv
// Default data memory of the core: answers d_* loads and byte-enabled stores
// from a single-port word array after a fixed number of wait states, and
// flags accesses that fall outside its address window.
module xrv_dmem #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic       clk,
    input logic       rstb,
    xrv_dmem_if.slave bus
);
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    // Window bounds in 33 bits so a window ending at 2^32 still compares correctly.
    localparam logic [32:0] WIN_LO    = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI    = WIN_LO + (33'(DEPTH_WORDS) << 2);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             op_wr_q, op_wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             in_range_q, in_range_d;
    logic             wr_ready_q, wr_ready_d;
    logic             rd_ready_q, rd_ready_d;
    logic             bus_err_q, bus_err_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             mem_we;
    logic             enter_resp;

    logic [IDX_W-1:0] idx_live;
    logic             in_range_live;
    logic             req_any;
    logic             req_held;

    // NOTE: the array is deliberately left out of reset; a reset must not wipe
    // data memory, and a resettable array cannot map onto a RAM macro. It only
    // starts from zero at power-up.
    logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0};

    assign in_range_live = ({1'b0, bus.d_addr} >= WIN_LO) && ({1'b0, bus.d_addr} < WIN_HI);
    assign idx_live      = IDX_W'((bus.d_addr - BASE_ADDR) >> 2);
    assign req_any       = bus.d_wr_req | bus.d_rd_req;
    // The request line that belongs to the operation currently in flight.
    assign req_held      = op_wr_q ? bus.d_wr_req : bus.d_rd_req;

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: clocked blocks use non-blocking assignments so every flop
            // updates from the values present before the edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: accept in IDLE, count down in WAIT, respond for one cycle.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req_held) begin
                    // Initiator withdrew the request: drop it silently.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture and next values of the registered outputs.
    always_comb begin
        op_wr_d    = op_wr_q;
        idx_d      = idx_q;
        in_range_d = in_range_q;
        if (state_q == ST_IDLE) begin
            // Write wins when both request lines are high.
            op_wr_d    = bus.d_wr_req;
            idx_d      = idx_live;
            in_range_d = in_range_live;
        end

        enter_resp = (state_d == ST_RESP);
        wr_ready_d = enter_resp && op_wr_d;
        rd_ready_d = enter_resp && !op_wr_d;
        bus_err_d  = enter_resp && !in_range_d;
        mem_we     = enter_resp && op_wr_d && in_range_d;

        rd_data_d = rd_data_q;
        if (enter_resp && !op_wr_d) begin
            rd_data_d = in_range_d ? mem_q[idx_d] : 32'h0;
        end
    end

    // Latched request and output registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            op_wr_q    <= 1'b0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_ready_q <= 1'b0;
            bus_err_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            op_wr_q    <= op_wr_d;
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
            wr_ready_q <= wr_ready_d;
            rd_ready_q <= rd_ready_d;
            bus_err_q  <= bus_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Byte-lane store, committed on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.d_be[i]) begin
                    mem_q[idx_d][8*i +: 8] <= bus.d_wr_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.d_wr_ready = wr_ready_q;
    assign bus.d_rd_ready = rd_ready_q;
    assign bus.d_rd_data  = rd_data_q;
    assign bus.bus_err    = bus_err_q;
endmodule

// File: tb/tb_xrv_dmem.sv
// Bench for xrv_dmem: a WAIT_CYCLES=1 instance carries the functional tests,
// WAIT_CYCLES=0 and WAIT_CYCLES=15 instances carry the latency/spacing tests.
`timescale 1ns/1ps
module tb_xrv_dmem;
    localparam int unsigned DEPTH  = 4096;
    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam int          W_MAIN = 1;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_err    = 0;

    xrv_dmem_if m_if ();
    xrv_dmem_if f_if ();
    xrv_dmem_if s_if ();

    xrv_dmem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W_MAIN))
        u_dut  (.clk(clk), .rstb(rstb), .bus(m_if));
    xrv_dmem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0))
        u_fast (.clk(clk), .rstb(rstb), .bus(f_if));
    xrv_dmem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(15))
        u_slow (.clk(clk), .rstb(rstb), .bus(s_if));

    // Ready pulse counters, sampled mid-cycle.
    int pulses_m = 0, pulses_f = 0, pulses_s = 0;
    always @(negedge clk) begin
        if (m_if.d_wr_ready) pulses_m++;
        if (m_if.d_rd_ready) pulses_m++;
        if (f_if.d_rd_ready) pulses_f++;
        if (s_if.d_rd_ready) pulses_s++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model: sparse word store ----------------
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] last_rd = 32'h0;

    function automatic bit ref_in_window(input logic [31:0] a);
        longint unsigned x  = a;
        longint unsigned lo = BASE;
        longint unsigned hi = longint'(BASE) + 4 * longint'(DEPTH);
        return (x >= lo) && (x < hi);
    endfunction

    task automatic ref_op(input bit wr, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d, output logic [31:0] exp_rd, output bit exp_err);
        int unsigned w;
        logic [31:0] cur;
        longint unsigned x = a;
        exp_err = !ref_in_window(a);
        exp_rd  = 32'h0;
        if (!exp_err) begin
            w   = int'((x - longint'(BASE)) / 4);
            cur = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
            if (wr) begin
                for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = d[8*i +: 8];
                ref_mem[w] = cur;
            end else begin
                exp_rd = cur;
            end
        end
        if (!wr) last_rd = exp_rd;
    endtask

    // ---------------- main-DUT drivers ----------------
    // Wait (bounded) for a ready pulse; returns at the negedge of the ready cycle.
    task automatic wait_ready(input int t0, output int lat, output logic gw, output logic gr,
                              output logic [31:0] rd, output logic er);
        bit seen = 0;
        lat = -1; gw = 1'b0; gr = 1'b0; rd = 32'hx; er = 1'bx;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (m_if.d_wr_ready || m_if.d_rd_ready) begin
                seen = 1;
                lat  = cyc - t0;
                gw   = m_if.d_wr_ready;
                gr   = m_if.d_rd_ready;
                rd   = m_if.d_rd_data;
                er   = m_if.bus_err;
            end
        end
    endtask

    // Full handshake; called and returns just after a rising edge.
    task automatic access(input bit wr, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                          output int lat, output logic gw, output logic gr,
                          output logic [31:0] rd, output logic er);
        m_if.d_addr = a; m_if.d_be = be; m_if.d_wr_data = d;
        if (wr) m_if.d_wr_req = 1'b1; else m_if.d_rd_req = 1'b1;
        wait_ready(cyc, lat, gw, gr, rd, er);
        @(posedge clk); #1;
        m_if.d_wr_req = 1'b0; m_if.d_rd_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_op(input string name, input bit wr, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d, output logic [31:0] got_rd, output logic got_err,
                          output logic [31:0] exp_rd, output bit exp_err);
        int lat;
        logic gw, gr;
        logic [31:0] hold_exp = last_rd;
        ref_op(wr, a, be, d, exp_rd, exp_err);
        access(wr, a, be, d, lat, gw, gr, got_rd, got_err);
        check({name, " latency"}, 32'(lat), 32'(1 + W_MAIN));
        check({name, " ready kind"}, {30'd0, gw, gr}, wr ? 32'd2 : 32'd1);
        if (wr) check({name, " rd_data hold"}, got_rd, hold_exp);
    endtask

    // ---------------- latency instances ----------------
    task automatic lat_run(input bit slow);
        int w = slow ? 15 : 0;
        int prev = 0;
        int t0, r;
        string nm = slow ? "w15" : "w0";
        for (int i = 0; i < 8; i++) begin
            if (slow) begin s_if.d_addr = BASE + 32'(4*i); s_if.d_rd_req = 1'b1; end
            else      begin f_if.d_addr = BASE + 32'(4*i); f_if.d_rd_req = 1'b1; end
            t0 = cyc; r = -1;
            for (int k = 0; k < 40 && r < 0; k++) begin
                @(negedge clk);
                if (slow ? s_if.d_rd_ready : f_if.d_rd_ready) begin
                    r = cyc;
                    check({nm, " data"}, slow ? s_if.d_rd_data : f_if.d_rd_data, 32'h0);
                    check({nm, " bus_err"}, {31'd0, slow ? s_if.bus_err : f_if.bus_err}, 32'd0);
                end
            end
            check($sformatf("%s latency %0d", nm, i), (r < 0) ? 32'hFFFF_FFFF : 32'(r - t0), 32'(w + 1));
            if (i > 0) check($sformatf("%s spacing %0d", nm, i), {31'd0, (r - prev) >= (w + 2)}, 32'd1);
            prev = r;
            @(posedge clk); #1;
            s_if.d_rd_req = 1'b0; f_if.d_rd_req = 1'b0;
            @(posedge clk); #1;
        end
        repeat (20) @(posedge clk);
        #1;
        check({nm, " pulse count"}, 32'(slow ? pulses_s : pulses_f), 32'd8);
    endtask

    // ---------------- table vectors ----------------
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got_rd, exp_rd, a, d, rd;
        logic        got_err, gw, gr, er;
        bit          exp_err, wr;
        logic [3:0]  be;
        int          lat, snap;

        vecs[0]  = '{wr:1, addr:BASE,              be:4'hF, data:32'hDEAD_BEEF, exp_rd:32'h0,         exp_err:0};
        vecs[1]  = '{wr:0, addr:BASE,              be:4'h0, data:32'h0,         exp_rd:32'hDEAD_BEEF, exp_err:0};
        vecs[2]  = '{wr:1, addr:BASE + 32'h4,      be:4'hF, data:32'h1122_3344, exp_rd:32'h0,         exp_err:0};
        vecs[3]  = '{wr:1, addr:BASE + 32'h4,      be:4'h2, data:32'h0000_AB00, exp_rd:32'h0,         exp_err:0};
        vecs[4]  = '{wr:1, addr:BASE + 32'h4,      be:4'hC, data:32'hCDEF_0000, exp_rd:32'h0,         exp_err:0};
        vecs[5]  = '{wr:0, addr:BASE + 32'h4,      be:4'h0, data:32'h0,         exp_rd:32'hCDEF_AB44, exp_err:0};
        vecs[6]  = '{wr:0, addr:32'h0000_FFFC,     be:4'h0, data:32'h0,         exp_rd:32'h0,         exp_err:1};
        vecs[7]  = '{wr:1, addr:BASE + 32'h4000,   be:4'hF, data:32'hFFFF_FFFF, exp_rd:32'h0,         exp_err:1};
        vecs[8]  = '{wr:0, addr:32'hFFFF_FFFC,     be:4'h0, data:32'h0,         exp_rd:32'h0,         exp_err:1};
        vecs[9]  = '{wr:0, addr:BASE,              be:4'h0, data:32'h0,         exp_rd:32'hDEAD_BEEF, exp_err:0};
        vecs[10] = '{wr:1, addr:BASE + 32'h3FFC,   be:4'hF, data:32'h0F0E_0D0C, exp_rd:32'h0,         exp_err:0};
        vecs[11] = '{wr:0, addr:BASE + 32'h3FFF,   be:4'h0, data:32'h0,         exp_rd:32'h0F0E_0D0C, exp_err:0};
        vecs[12] = '{wr:1, addr:BASE,              be:4'h0, data:32'h0,         exp_rd:32'h0,         exp_err:0};
        vecs[13] = '{wr:0, addr:BASE + 32'h2,      be:4'h0, data:32'h0,         exp_rd:32'hDEAD_BEEF, exp_err:0};

        m_if.d_addr = '0; m_if.d_wr_req = 0; m_if.d_rd_req = 0; m_if.d_be = '0; m_if.d_wr_data = '0;
        f_if.d_addr = '0; f_if.d_wr_req = 0; f_if.d_rd_req = 0; f_if.d_be = '0; f_if.d_wr_data = '0;
        s_if.d_addr = '0; s_if.d_wr_req = 0; s_if.d_rd_req = 0; s_if.d_be = '0; s_if.d_wr_data = '0;

        // Reset state
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        check("reset wr_ready", {31'd0, m_if.d_wr_ready}, 32'd0);
        check("reset rd_ready", {31'd0, m_if.d_rd_ready}, 32'd0);
        check("reset bus_err",  {31'd0, m_if.bus_err},    32'd0);
        check("reset rd_data",  m_if.d_rd_data,           32'd0);
        @(posedge clk); #1 rstb = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].data,
                   got_rd, got_err, exp_rd, exp_err);
            if (!vecs[i].wr) check($sformatf("vec%0d rd_data", i), got_rd, vecs[i].exp_rd);
            check($sformatf("vec%0d bus_err", i), {31'd0, got_err}, {31'd0, vecs[i].exp_err});
        end

        // Simultaneous store and load: store served first, load follows with new data
        ref_op(1, BASE + 32'h8, 4'hF, 32'hA5A5_0F0F, exp_rd, exp_err);
        m_if.d_addr = BASE + 32'h8; m_if.d_be = 4'hF; m_if.d_wr_data = 32'hA5A5_0F0F;
        m_if.d_wr_req = 1'b1; m_if.d_rd_req = 1'b1;
        wait_ready(cyc, lat, gw, gr, rd, er);
        check("dual first latency", 32'(lat), 32'd2);
        check("dual first kind", {30'd0, gw, gr}, 32'd2);
        @(posedge clk); #1 m_if.d_wr_req = 1'b0;
        wait_ready(cyc, lat, gw, gr, rd, er);
        check("dual second latency", 32'(lat), 32'd2);
        check("dual second kind", {30'd0, gw, gr}, 32'd1);
        check("dual read data", rd, 32'hA5A5_0F0F);
        ref_op(0, BASE + 32'h8, 4'h0, 32'h0, exp_rd, exp_err);
        @(posedge clk); #1 m_if.d_rd_req = 1'b0;
        @(posedge clk); #1;

        // Request withdrawn during WAIT: no ready, no write
        snap = pulses_m;
        m_if.d_addr = BASE + 32'hC; m_if.d_be = 4'hF; m_if.d_wr_data = 32'h1234_5678; m_if.d_wr_req = 1'b1;
        @(posedge clk); #1 m_if.d_wr_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort no ready", 32'(pulses_m), 32'(snap));
        run_op("abort readback", 0, BASE + 32'hC, 4'h0, 32'h0, got_rd, got_err, exp_rd, exp_err);
        check("abort readback data", got_rd, exp_rd);

        // Reset during WAIT of a store: outputs clear at once, old word survives
        run_op("pre wait", 1, BASE + 32'h10, 4'hF, 32'h0BAD_F00D, got_rd, got_err, exp_rd, exp_err);
        run_op("pre load", 0, BASE, 4'h0, 32'h0, got_rd, got_err, exp_rd, exp_err);
        m_if.d_addr = BASE + 32'h10; m_if.d_be = 4'hF; m_if.d_wr_data = 32'h55AA_55AA; m_if.d_wr_req = 1'b1;
        @(posedge clk); #2 rstb = 1'b0;
        #1;
        check("wait-reset rd_data",  m_if.d_rd_data, 32'h0);
        check("wait-reset wr_ready", {31'd0, m_if.d_wr_ready}, 32'd0);
        last_rd = 32'h0;
        @(posedge clk); #1 m_if.d_wr_req = 1'b0; rstb = 1'b1;
        @(posedge clk); #1;
        run_op("wait-reset readback", 0, BASE + 32'h10, 4'h0, 32'h0, got_rd, got_err, exp_rd, exp_err);
        check("wait-reset old word", got_rd, 32'h0BAD_F00D);

        // Reset during RESP of a store: ready drops at once, new word is kept
        m_if.d_addr = BASE + 32'h10; m_if.d_be = 4'hF; m_if.d_wr_data = 32'h55AA_55AA; m_if.d_wr_req = 1'b1;
        wait_ready(cyc, lat, gw, gr, rd, er);
        check("resp-reset ready seen", {31'd0, gw}, 32'd1);
        #1 rstb = 1'b0;
        #1;
        check("resp-reset wr_ready", {31'd0, m_if.d_wr_ready}, 32'd0);
        check("resp-reset bus_err",  {31'd0, m_if.bus_err},    32'd0);
        ref_op(1, BASE + 32'h10, 4'hF, 32'h55AA_55AA, exp_rd, exp_err);
        last_rd = 32'h0;
        @(posedge clk); #1 m_if.d_wr_req = 1'b0; rstb = 1'b1;
        @(posedge clk); #1;
        run_op("resp-reset readback", 0, BASE + 32'h10, 4'h0, 32'h0, got_rd, got_err, exp_rd, exp_err);
        check("resp-reset new word", got_rd, 32'h55AA_55AA);

        // Randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            wr = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            d  = $urandom;
            case ($urandom_range(0, 9))
                0:       a = BASE - 32'(4 * $urandom_range(1, 4));
                1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
                2:       a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                3:       a = BASE + 32'(4 * DEPTH - 4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
                default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            endcase
            run_op($sformatf("rnd%0d", i), wr, a, be, d, got_rd, got_err, exp_rd, exp_err);
            if (!wr) check($sformatf("rnd%0d rd_data", i), got_rd, exp_rd);
            check($sformatf("rnd%0d bus_err", i), {31'd0, got_err}, {31'd0, exp_err});
        end

        // Latency and spacing for the zero- and maximum-wait builds
        lat_run(1'b0);
        lat_run(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
